uart_tx_fifo_cfg: RTL and testbench

//  Parametrised UART transmitter, the next generation of the team's UART TX line.
//  - Front FIFO accepts AXI-Stream words.
//  - Serialises LSB-first frames: start, DATA_WIDTH data bits, optional parity, 1 or 2 stop bits.
//  - Frame format and baud are runtime-selectable and latched per frame.
//  - Sits between the AXI-Stream fabric and the txd pad.

---
 rtl/uart_tx_fifo_cfg_pkg.sv | 21 ++
 rtl/uart_tx_fifo_cfg_fifo.sv | 73 +++++++
 rtl/uart_tx_fifo_cfg.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_cfg_pkg.sv
// Shared definitions for the FIFO-fronted UART transmitter:
// parity encodings, FSM states and a clog2 helper that never returns zero.
package uart_tx_fifo_cfg_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int safe_clog2(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_fifo.sv
// Input FIFO for the UART transmitter: registered read data, separately tracked
// level so full and empty are unambiguous, registered write-ready.
module uart_tx_fifo_cfg_fifo
  import uart_tx_fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_ready,
  input  logic                              rd_en,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_nxt
);

  localparam int AW = safe_clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ready_q, ready_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(wr_en) - LW'(rd_en);
    ready_d = (level_d != LW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      ready_q   <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr_ready  = ready_q;
  assign rd_data   = rd_data_q;
  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Parametrised UART transmitter fed from an AXI-Stream FIFO. Frame format and baud
// are latched when a word is popped, so config changes only affect later frames.
module uart_tx_fifo_cfg
  import uart_tx_fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [15:0]                     prescale,
  input  logic [1:0]                      parity_mode,
  input  logic                            stop2,
  output logic                            txd,
  output logic                            busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int TW = 16 + $clog2(OVERSAMPLE);
  localparam int CW = safe_clog2(DATA_WIDTH + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [TW-1:0]         timer_q, timer_d, reload_q, reload_d, reload_new;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  stop2_q, stop2_d, par_bit_q, par_bit_d;
  logic                  txd_q, txd_d, tx_done_q, tx_done_d, busy_q, busy_d;
  logic                  push, pop, load_frame, bit_end, par_en;
  logic [15:0]           prescale_eff;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [LW-1:0]         level, level_nxt;

  assign push = s_axis_tvalid && s_axis_tready;

  uart_tx_fifo_cfg_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (s_axis_tdata),
    .wr_ready (s_axis_tready),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .level    (level),
    .level_nxt(level_nxt)
  );

  assign prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  assign reload_new   = TW'(prescale_eff) * TW'(OVERSAMPLE) - TW'(1);
  assign bit_end      = (timer_q == '0);
  assign par_en       = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);

  // The shifter is loaded at the start/data boundary, once the FIFO's registered
  // read data for the popped word is available.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    timer_d    = timer_q;
    reload_d   = reload_q;
    bit_cnt_d  = bit_cnt_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    tx_done_d  = 1'b0;
    load_frame = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (level != '0) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          shift_d   = fifo_data;
          par_bit_d = (par_mode_q == PAR_ODD) ? ~^fifo_data : ^fifo_data;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CW'(1);
          end else begin
            tx_done_d = 1'b1;
            if (level != '0) load_frame = 1'b1;
            else state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) timer_d = bit_end ? reload_q : timer_q - TW'(1);

    if (load_frame) begin
      pop        = 1'b1;
      state_d    = ST_START;
      timer_d    = reload_new;
      reload_d   = reload_new;
      par_mode_d = parity_mode;
      stop2_d    = stop2;
      bit_cnt_d  = '0;
    end

    // txd follows the state one clock later, giving the two-edge push-to-start latency.
    unique case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
      ST_PARITY: txd_d = par_bit_q;
      default:   txd_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE) || (level_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      timer_q    <= '0;
      reload_q   <= '0;
      bit_cnt_q  <= '0;
      par_mode_q <= PAR_NONE;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      txd_q      <= 1'b1;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      reload_q   <= reload_d;
      bit_cnt_q  <= bit_cnt_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      txd_q      <= txd_d;
      tx_done_q  <= tx_done_d;
      busy_q     <= busy_d;
    end
  end

  assign txd        = txd_q;
  assign tx_done    = tx_done_q;
  assign busy       = busy_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: a queue-based line model checked every cycle,
// directed frames pinned to hand-computed waveforms, then randomized traffic.
module tb_uart_tx_fifo_cfg;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int OS    = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic [15:0]   prescale;
  logic [1:0]    parity_mode;
  logic          stop2;
  logic          txd;
  logic          busy;
  logic          tx_done;
  logic [LW-1:0] fifo_level;

  int vectors     = 0;
  int miscompares = 0;
  bit model_on    = 1'b0;

  typedef struct packed {
    logic txd;
    logic done;
  } samp_t;

  samp_t         wave[$];
  logic [DW-1:0] fifo_model[$];

  uart_tx_fifo_cfg #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .OVERSAMPLE(OS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .prescale     (prescale),
    .parity_mode  (parity_mode),
    .stop2        (stop2),
    .txd          (txd),
    .busy         (busy),
    .tx_done      (tx_done),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expands one word into the per-clock line waveform it must produce.
  function automatic void appendFrame(input logic [DW-1:0] w, input logic [15:0] p,
                                      input logic [1:0] pm, input logic s2);
    int    bitclk;
    logic  bits[$];
    samp_t last;
    bitclk = ((p == 16'd0) ? 1 : int'(p)) * OS;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (pm == 2'b01) bits.push_back(^w);
    else if (pm == 2'b10) bits.push_back(~^w);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < bitclk; k++) wave.push_back('{txd: bits[i], done: 1'b0});
    last      = wave.pop_back();
    last.done = 1'b1;
    wave.push_back(last);
  endfunction

  // Line model: wave[0] is the expected line for the cycle being checked; a word
  // leaves the queue one edge before its start bit reaches the line.
  always @(negedge clk) begin : model_p
    samp_t         cur;
    logic          exp_busy;
    logic [DW-1:0] w;
    logic          do_push;
    if (model_on) begin
      cur      = (wave.size() > 0) ? wave[0] : '{txd: 1'b1, done: 1'b0};
      exp_busy = (wave.size() >= 2) || (fifo_model.size() != 0);
      checkOutput("txd", 32'(txd), 32'(cur.txd));
      checkOutput("tx_done", 32'(tx_done), 32'(cur.done));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("fifo_level", 32'(fifo_level), 32'(fifo_model.size()));
      checkOutput("tready", 32'(tready), 32'(fifo_model.size() != DEPTH));
      if (wave.size() > 0) void'(wave.pop_front());
      if (rst) begin
        wave.delete();
        fifo_model.delete();
      end else begin
        do_push = tvalid && (fifo_model.size() != DEPTH);
        if ((fifo_model.size() != 0) && (wave.size() <= 1)) begin
          w = fifo_model.pop_front();
          if (wave.size() == 0) wave.push_back('{txd: 1'b1, done: 1'b0});
          appendFrame(w, prescale, parity_mode, stop2);
        end
        if (do_push) fifo_model.push_back(tdata);
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] w);
    int waited;
    bit timed_out;
    waited    = 0;
    timed_out = 1'b0;
    tvalid    = 1'b1;
    tdata     = w;
    forever begin
      @(negedge clk);
      if (tready) break;
      waited++;
      if (waited > 5000) begin
        timed_out = 1'b1;
        break;
      end
    end
    checkOutput("push_timeout", 32'(timed_out), 32'd0);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic waitStart(output int lat);
    bit timed_out;
    lat       = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) break;
      lat++;
      if (lat > 5000) begin
        timed_out = 1'b1;
        break;
      end
    end
    checkOutput("start_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic captureFrame(input int nbits, input int bitclk, output logic [31:0] bits,
                              output int done1, output int done2);
    bits  = '0;
    done1 = -1;
    done2 = -1;
    for (int j = 0; j < nbits * bitclk; j++) begin
      if (j > 0) @(negedge clk);
      if ((j % bitclk) == (bitclk / 2)) bits[j / bitclk] = txd;
      if (tx_done === 1'b1) begin
        if (done1 < 0) done1 = j;
        else done2 = j;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int waited;
    bit timed_out;
    waited    = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      waited++;
      if (waited > 20000) begin
        timed_out = 1'b1;
        break;
      end
    end
    checkOutput("idle_timeout", 32'(timed_out), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim_p
    int          lat, d1, d2, gap, done_seen;
    logic [31:0] bits;
    rst         = 1'b1;
    tvalid      = 1'b0;
    tdata       = '0;
    prescale    = 16'd1;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;
    @(negedge clk);
    checkOutput("rst_txd", 32'(txd), 32'd1);
    checkOutput("rst_tready", 32'(tready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] T1 plain 8N1 frame");
    applyStimulus(8'hA5);
    waitStart(lat);
    checkOutput("t1_latency", 32'(lat), 32'd2);
    captureFrame(10, 8, bits, d1, d2);
    checkOutput("t1_bits", bits, 32'h34A);
    checkOutput("t1_done_clk", 32'(d1), 32'd79);

    $display("[TB] T2 even and odd parity");
    parity_mode = 2'b01;
    applyStimulus(8'h07);
    waitStart(lat);
    captureFrame(11, 8, bits, d1, d2);
    checkOutput("t2_even_par", 32'(bits[9]), 32'd1);
    checkOutput("t2_even_done", 32'(d1), 32'd87);
    parity_mode = 2'b10;
    applyStimulus(8'h07);
    waitStart(lat);
    captureFrame(11, 8, bits, d1, d2);
    checkOutput("t2_odd_par", 32'(bits[9]), 32'd0);

    $display("[TB] T3 two stop bits back-to-back");
    parity_mode = 2'b00;
    stop2       = 1'b1;
    applyStimulus(8'h3C);
    applyStimulus(8'hC3);
    waitStart(lat);
    captureFrame(22, 8, bits, d1, d2);
    checkOutput("t3_bits", bits, 32'({11'b11110000110, 11'b11001111000}));
    checkOutput("t3_done1", 32'(d1), 32'd87);
    checkOutput("t3_done2", 32'(d2), 32'd175);

    $display("[TB] T4 fill the FIFO");
    stop2    = 1'b0;
    prescale = 16'd2;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(DW'(8'h10 + i));
      if (i == 4) begin
        @(negedge clk);
        checkOutput("t4_level_full", 32'(fifo_level), 32'd4);
        checkOutput("t4_tready_low", 32'(tready), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    waitIdle();

    $display("[TB] T5 reset mid-frame");
    prescale = 16'd1;
    applyStimulus(8'h96);
    waitStart(lat);
    repeat (34) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_txd", 32'(txd), 32'd1);
    checkOutput("t5_level", 32'(fifo_level), 32'd0);
    checkOutput("t5_tready", 32'(tready), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen++;
    end
    checkOutput("t5_no_done", 32'(done_seen), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] T6 prescale zero");
    prescale = 16'd0;
    applyStimulus(8'h5A);
    waitStart(lat);
    checkOutput("t6_latency", 32'(lat), 32'd2);
    captureFrame(10, 8, bits, d1, d2);
    checkOutput("t6_bits", bits, 32'h2B4);
    checkOutput("t6_done_clk", 32'(d1), 32'd79);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      prescale    = 16'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      stop2       = 1'($urandom_range(0, 1));
      applyStimulus(DW'($urandom));
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300))
                                        : int'($urandom_range(0, 3));
      repeat (gap) begin
        @(posedge clk);
        #1;
        if ($urandom_range(0, 3) == 0) begin
          prescale    = 16'($urandom_range(0, 3));
          parity_mode = 2'($urandom_range(0, 3));
          stop2       = 1'($urandom_range(0, 1));
        end
      end
    end
    waitIdle();
    repeat (4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
